// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
// -----------------------------------------------------------------------------
// Purpose:
//   APB3 requester. Accepts one command at a time on a valid/ready interface,
//   runs a single APB transfer (SETUP, then ACCESS until PREADY) and returns a
//   one-cycle registered response with read data and error status.
//
// Optional feature:
//   APB_MASTER_TIMEOUT_EN - when defined, an ACCESS-phase watchdog aborts a
//   transfer that sees PREADY low for TIMEOUT_CYCLES consecutive ACCESS cycles.
//   When undefined, ACCESS waits indefinitely and rsp_timeout is tied to 0.
//
// Ports:
//   PCLK, PRESET            clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_write/addr/wdata    command payload
//   rsp_valid               one-cycle response pulse
//   rsp_rdata/err/timeout   response payload (held between responses)
//   PADDR/PSEL/PENABLE/
//   PWRITE/PWDATA           APB request outputs (all registered)
//   PREADY/PRDATA/PSLVERR   APB completer inputs
// -----------------------------------------------------------------------------
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PSLVERR
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_cmd_ready;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;

`ifdef APB_MASTER_TIMEOUT_EN
    // Counter wide enough to hold TIMEOUT_CYCLES-1 for any TIMEOUT_CYCLES >= 1.
    localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LP_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_rsp_timeout;
`else
    // TIMEOUT_CYCLES only matters when the watchdog is built in.
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // Transfer FSM with registered APB outputs, command ready and response.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state       <= ST_IDLE;
            r_cmd_ready   <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= {ADDR_WIDTH{1'b0}};
            r_pwdata      <= {DATA_WIDTH{1'b0}};
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= {DATA_WIDTH{1'b0}};
            r_rsp_err     <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            r_wait_cnt    <= {CNT_W{1'b0}};
            r_rsp_timeout <= 1'b0;
`endif
        end else begin
            // Response is a single-cycle pulse; payload holds its last value.
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_paddr     <= cmd_addr;
                        r_pwrite    <= cmd_write;
                        r_pwdata    <= cmd_wdata;
                        r_psel      <= 1'b1;
                        r_penable   <= 1'b0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ST_SETUP;
                    end else begin
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    r_wait_cnt <= {CNT_W{1'b0}};
`endif
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        // Read data is only returned for successful reads.
                        r_rsp_rdata <= (!r_pwrite && !PSLVERR) ? PRDATA : {DATA_WIDTH{1'b0}};
                        r_rsp_err   <= PSLVERR;
                        r_rsp_valid <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
`ifdef APB_MASTER_TIMEOUT_EN
                        r_rsp_timeout <= 1'b0;
                    end else if (r_wait_cnt == LP_LAST) begin
                        // Watchdog expired: abort with an error response.
                        r_rsp_rdata   <= {DATA_WIDTH{1'b0}};
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_cmd_ready   <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                        r_state    <= ST_ACCESS;
                    end
`else
                    end else begin
                        r_state <= ST_ACCESS;
                    end
`endif
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
`ifdef APB_MASTER_TIMEOUT_EN
    assign rsp_timeout = r_rsp_timeout;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
// -----------------------------------------------------------------------------
// Directed, table-driven bench for apb_master. The bench plays the APB
// completer itself (PREADY/PRDATA/PSLVERR per vector) and checks every
// cycle of each transfer. Hand-written sequences cover back-to-back commands,
// reset in the middle of ACCESS and the watchdog (or its absence).
// -----------------------------------------------------------------------------
module tb_apb_master;

    logic        PCLK;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    int checks;
    int errors;

    apb_master #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .PADDR      (PADDR),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PREADY     (PREADY),
        .PRDATA     (PRDATA),
        .PSLVERR    (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          waits;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Runs one full transfer from a vector, checking every cycle.
    task automatic run_vec(input vec_t v);
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        chk("idle_ready", 32'(cmd_ready), 32'd1);
        // SETUP cycle; a junk command held valid must be ignored while busy.
        @(negedge PCLK);
        cmd_addr  = 32'hFFFF_0000;
        cmd_wdata = 32'h0BAD_F00D;
        cmd_write = ~v.write;
        PREADY    = 1'b0;
        chk("setup_psel",    32'(PSEL),      32'd1);
        chk("setup_penable", 32'(PENABLE),   32'd0);
        chk("setup_ready",   32'(cmd_ready), 32'd0);
        chk("setup_paddr",   PADDR,          v.addr);
        chk("setup_pwrite",  32'(PWRITE),    32'(v.write));
        chk("setup_pwdata",  PWDATA,         v.wdata);
        // ACCESS cycles: waits low-PREADY cycles carrying junk, then completion.
        for (int w = 0; w <= v.waits; w++) begin
            @(negedge PCLK);
            chk("acc_psel",    32'(PSEL),      32'd1);
            chk("acc_penable", 32'(PENABLE),   32'd1);
            chk("acc_rsp",     32'(rsp_valid), 32'd0);
            chk("acc_paddr",   PADDR,          v.addr);
            chk("acc_pwdata",  PWDATA,         v.wdata);
            if (w == v.waits) begin
                PREADY  = 1'b1;
                PSLVERR = v.slverr;
                PRDATA  = v.prdata;
            end else begin
                PREADY  = 1'b0;
                PSLVERR = 1'b1;
                PRDATA  = 32'hBAD0_BAD0;
            end
        end
        // Response cycle.
        @(negedge PCLK);
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        PRDATA    = 32'h0;
        chk("rsp_valid",   32'(rsp_valid),   32'd1);
        chk("rsp_rdata",   rsp_rdata,        v.exp_rdata);
        chk("rsp_err",     32'(rsp_err),     32'(v.exp_err));
        chk("rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("rsp_ready",   32'(cmd_ready),   32'd1);
        chk("rsp_psel",    32'(PSEL),        32'd0);
        // Following cycle: pulse gone, payload and APB address held.
        @(negedge PCLK);
        chk("post_valid", 32'(rsp_valid), 32'd0);
        chk("post_rdata", rsp_rdata,      v.exp_rdata);
        chk("post_paddr", PADDR,          v.addr);
        chk("post_psel",  32'(PSEL),      32'd0);
    endtask

    initial begin
        int n;
        checks    = 0;
        errors    = 0;
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        PREADY    = 1'b0;
        PRDATA    = 32'h0;
        PSLVERR   = 1'b0;

        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h5555_5555, 0, 1'b0, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 2, 1'b0, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0800, 32'h0000_0000, 32'h1234_5678, 0, 1'b1, 32'h0000_0000, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_0020, 32'hCAFE_0001, 32'h7777_7777, 1, 1'b1, 32'h0000_0000, 1'b1};
        vecs[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'hA5A5_A5A5, 3, 1'b0, 32'hA5A5_A5A5, 1'b0};

        // Reset state.
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        chk("rst_psel",    32'(PSEL),        32'd0);
        chk("rst_penable", 32'(PENABLE),     32'd0);
        chk("rst_paddr",   PADDR,            32'd0);
        chk("rst_pwdata",  PWDATA,           32'd0);
        chk("rst_pwrite",  32'(PWRITE),      32'd0);
        chk("rst_rsp",     32'(rsp_valid),   32'd0);
        chk("rst_rdata",   rsp_rdata,        32'd0);
        chk("rst_err",     32'(rsp_err),     32'd0);
        chk("rst_tmo",     32'(rsp_timeout), 32'd0);
        chk("rst_ready",   32'(cmd_ready),   32'd1);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end

        // Back-to-back: second command accepted in the rsp_valid cycle.
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0040;
        cmd_wdata = 32'h0000_AAAA;
        @(negedge PCLK);                       // SETUP of A
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0044;
        cmd_wdata = 32'h0;
        @(negedge PCLK);                       // ACCESS of A
        PREADY = 1'b1;
        PRDATA = 32'h1122_3344;
        @(negedge PCLK);                       // rsp of A, B accepted at next edge
        chk("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("b2b_rsp_ready", 32'(cmd_ready), 32'd1);
        chk("b2b_rsp_psel",  32'(PSEL),      32'd0);
        chk("b2b_rsp_addr",  PADDR,          32'h0000_0040);
        @(negedge PCLK);                       // SETUP of B
        cmd_valid = 1'b0;
        chk("b2b_setup_psel", 32'(PSEL),    32'd1);
        chk("b2b_setup_pen",  32'(PENABLE), 32'd0);
        chk("b2b_setup_addr", PADDR,        32'h0000_0044);
        chk("b2b_setup_rsp",  32'(rsp_valid), 32'd0);
        @(negedge PCLK);                       // ACCESS of B, PREADY still 1
        chk("b2b_acc_pen", 32'(PENABLE), 32'd1);
        @(negedge PCLK);
        PREADY = 1'b0;
        chk("b2b_b_valid", 32'(rsp_valid), 32'd1);
        chk("b2b_b_rdata", rsp_rdata,      32'h1122_3344);
        chk("b2b_b_err",   32'(rsp_err),   32'd0);

        // Reset during the second ACCESS wait cycle.
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0100;
        cmd_wdata = 32'h1357_9BDF;
        @(negedge PCLK);                       // SETUP
        cmd_valid = 1'b0;
        @(negedge PCLK);                       // ACCESS wait 1
        @(negedge PCLK);                       // ACCESS wait 2
        chk("prst_acc_pen", 32'(PENABLE), 32'd1);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        chk("prst_psel",   32'(PSEL),      32'd0);
        chk("prst_pen",    32'(PENABLE),   32'd0);
        chk("prst_paddr",  PADDR,          32'd0);
        chk("prst_pwdata", PWDATA,         32'd0);
        chk("prst_rdata",  rsp_rdata,      32'd0);
        chk("prst_rsp",    32'(rsp_valid), 32'd0);
        chk("prst_ready",  32'(cmd_ready), 32'd1);
        PREADY = 1'b1;
        n = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge PCLK);
            if (rsp_valid || PSEL) n++;
        end
        PREADY = 1'b0;
        chk("prst_no_rsp", 32'(n), 32'd0);

        // Stuck PREADY: watchdog abort, or indefinite wait without it.
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0200;
        @(negedge PCLK);                       // SETUP
        cmd_valid = 1'b0;
        PRDATA    = 32'hDEAD_0000;
`ifdef APB_MASTER_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            @(negedge PCLK);
            chk("tmo_acc_psel", 32'(PSEL & PENABLE), 32'd1);
            chk("tmo_acc_rsp",  32'(rsp_valid),      32'd0);
        end
        @(negedge PCLK);
        chk("tmo_valid", 32'(rsp_valid),   32'd1);
        chk("tmo_err",   32'(rsp_err),     32'd1);
        chk("tmo_flag",  32'(rsp_timeout), 32'd1);
        chk("tmo_rdata", rsp_rdata,        32'd0);
        chk("tmo_psel",  32'(PSEL),        32'd0);
        chk("tmo_ready", 32'(cmd_ready),   32'd1);
`else
        n = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge PCLK);
            if (PSEL && PENABLE && !rsp_valid) n++;
        end
        chk("hold_100", 32'(n), 32'd100);
        PREADY = 1'b1;
        n = 0;
        // Bounded wait for the completion pulse once PREADY finally rises.
        for (int c = 0; c < 4 && n == 0; c++) begin
            @(negedge PCLK);
            PREADY = 1'b0;
            if (rsp_valid) n = 1;
        end
        chk("hold_done",  32'(n),           32'd1);
        chk("hold_rdata", rsp_rdata,        32'hDEAD_0000);
        chk("hold_tmo",   32'(rsp_timeout), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master.md
# apb_master

APB requester that converts a simple valid/ready command interface into single APB3 transfers (SETUP then ACCESS with PREADY wait states) and returns a one-cycle response carrying read data and error status. It sits between on-chip control logic or the UVM stimulus driver and any APB completer, including the team's memory-backed APB slave. It issues one transfer at a time, with no pipelining and no outstanding requests.

## Interface
- ADDR_WIDTH, 32, width of cmd_addr and PADDR
- DATA_WIDTH, 32, width of all data buses
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low; used only with the timeout macro
- PCLK  input  1  clock; all logic on rising edge
- PRESET  input  1  reset, synchronous, active-high
- cmd_valid  input  1  command request
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at rising edge
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_WIDTH  transfer address
- cmd_wdata  input  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and for errored transfers
- rsp_err  output  1  transfer ended with PSLVERR or timeout
- rsp_timeout  output  1  transfer aborted by the watchdog
- PADDR  output  ADDR_WIDTH  APB address
- PSEL  output  1  APB select
- PENABLE  output  1  APB enable
- PWRITE  output  1  APB direction
- PWDATA  output  DATA_WIDTH  APB write data
- PREADY  input  1  completer ready
- PRDATA  input  DATA_WIDTH  completer read data
- PSLVERR  input  1  completer error, sampled only with PREADY

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready = 1.
  - On handshake, register cmd_addr/cmd_write/cmd_wdata into PADDR/PWRITE/PWDATA and go to SETUP.
- SETUP: PSEL=1, PENABLE=0, cmd_ready=0. Unconditionally go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - PREADY=0: stay in ACCESS; address, data and control held stable.
  - PREADY=1: transfer completes at this edge. Capture PRDATA (read && !PSLVERR) and PSLVERR, then go to IDLE.
- Response is registered:
  - rsp_valid = 1 for exactly the cycle after the completion edge, with rsp_rdata, rsp_err and rsp_timeout valid in that cycle.
  - Outside that cycle rsp_rdata, rsp_err and rsp_timeout hold their last values.
- PADDR, PWRITE and PWDATA hold their last values after the transfer; they change only on command acceptance.
- All outputs are driven from registers, with no combinational path from the command interface to APB outputs.

## Timing
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, FSM=IDLE, so cmd_ready=1 in the first cycle after reset.
- Handshake at edge N:
  - SETUP in cycle N+1.
  - ACCESS from cycle N+2.
  - With zero wait states: rsp_valid and cmd_ready both high in cycle N+3.
- Each PREADY-low ACCESS cycle adds 1 cycle. Minimum throughput is 1 transfer per 3 cycles.
- A new command may be accepted in the same cycle that rsp_valid is high.
- cmd_valid while cmd_ready=0 is ignored. The requester holds the command until accepted.
- PRESET during SETUP or ACCESS:
  - PSEL and PENABLE drop at the next edge.
  - No response is generated; the transfer is lost.
- PSLVERR and PRDATA are ignored when PREADY=0.

## Configuration
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY=0.
  - If PREADY is still 0 in the TIMEOUT_CYCLES-th ACCESS cycle, the transfer aborts at that edge: go to IDLE, PSEL=0 and PENABLE=0 next cycle.
  - The aborted transfer's response is rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY=1 in that same cycle takes priority and completes normally.
- Undefined:
  - There is no counter; ACCESS waits indefinitely.
  - rsp_timeout is tied 0 and TIMEOUT_CYCLES is unused.

## Test plan
- Write 0xDEADBEEF to 0x10, PREADY held 1 -> PSEL then PSEL+PENABLE with PADDR=0x10, PWDATA=0xDEADBEEF, PWRITE=1. rsp_valid 3 cycles after the handshake with rsp_err=0, rsp_rdata=0.
- Read 0x10 with PRDATA=0xDEADBEEF and 2 PREADY-low wait cycles -> ACCESS lasts 3 cycles with signals stable. rsp_rdata=0xDEADBEEF, rsp_valid 5 cycles after the handshake.
- Read 0x800 with PREADY=1 and PSLVERR=1 -> rsp_err=1, rsp_rdata=0, rsp_timeout=0. cmd_ready returns high in the rsp_valid cycle.
- Back-to-back: a second command is held valid and accepted in the rsp_valid cycle -> its SETUP follows one cycle later. No overlap of PSEL between transfers beyond the required phases.
- PRESET asserted during the second ACCESS wait cycle -> PSEL=0, PENABLE=0 and all outputs at reset values next cycle. No rsp_valid; cmd_ready=1.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4, PREADY stuck 0 -> abort after 4 ACCESS cycles with rsp_err=1 and rsp_timeout=1. Without the macro the bench observes ACCESS held for 100 cycles with no response.
